// File: rtl/decode_stage_ctrl.sv
`default_nettype none
// ============================================================================
// decode_stage_ctrl : MIPS decode into the ID/EX register, with RI/ERET squash
// Rev 1.0
// ============================================================================
module decode_stage_ctrl #(
  parameter int EXC_W       = 6,
  parameter int RI_CODE     = 10,
  parameter int ERET_SQUASH = 1,
  parameter int PC_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [EXC_W-1:0] in_exc,
  input  logic             in_bd,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [PC_W-1:0]  out_pc,
  output logic [31:0]      out_instr,
  output logic [1:0]       out_reg_dst,
  output logic [1:0]       out_alu_src,
  output logic [2:0]       out_mem_to_reg,
  output logic             out_reg_write,
  output logic             out_mem_write,
  output logic [1:0]       out_npc_sel,
  output logic [1:0]       out_ext_op,
  output logic [3:0]       out_alu_ctr,
  output logic             out_write_cp0,
  output logic             out_eret,
  output logic [EXC_W-1:0] out_exc,
  output logic             out_bd,
  output logic             squash_pending
);
  localparam logic [0:0]       ST_RUN    = 1'b0;
  localparam logic [0:0]       ST_SQUASH = 1'b1;
  localparam logic [EXC_W-2:0] RI_TAG    = RI_CODE[EXC_W-2:0];

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] alu_src;
    logic [2:0] mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] npc_sel;
    logic [1:0] ext_op;
    logic [3:0] alu_ctr;
    logic       write_cp0;
    logic       eret;
  } ctrl_t;

  logic [5:0] op, funct;
  logic [4:0] rs;
  ctrl_t      dec;
  logic       dec_ok;

  assign op    = in_instr[31:26];
  assign rs    = in_instr[25:21];
  assign funct = in_instr[5:0];

  always_comb begin
    dec    = '0;
    dec_ok = 1'b1;
    case (op)
      6'h00: begin
        dec.reg_dst   = 2'd1;
        dec.reg_write = 1'b1;
        case (funct)
          6'h20, 6'h21: dec.alu_ctr = 4'd1;
          6'h22, 6'h23: dec.alu_ctr = 4'd2;
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
            dec.alu_src = 2'd2;
            dec.alu_ctr = 4'd4;
          end
          6'h24: dec.alu_ctr = 4'd5;
          6'h25: dec.alu_ctr = 4'd3;
          6'h26: dec.alu_ctr = 4'd6;
          6'h27: dec.alu_ctr = 4'd7;
          6'h2a: dec.alu_ctr = 4'd8;
          6'h2b: dec.alu_ctr = 4'd9;
          6'h08: begin
            dec.reg_dst   = 2'd0;
            dec.reg_write = 1'b0;
            dec.npc_sel   = 2'd3;
          end
          6'h09: begin
            dec.npc_sel    = 2'd3;
            dec.mem_to_reg = 3'd2;
          end
          default: dec_ok = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
        dec.alu_src   = 2'd1;
        dec.reg_write = 1'b1;
        case (op)
          6'h08, 6'h09: begin dec.ext_op = 2'd1; dec.alu_ctr = 4'd1; end
          6'h0a:        begin dec.ext_op = 2'd1; dec.alu_ctr = 4'd8; end
          6'h0b:        begin dec.ext_op = 2'd1; dec.alu_ctr = 4'd9; end
          6'h0c:        dec.alu_ctr = 4'd5;
          6'h0d:        dec.alu_ctr = 4'd3;
          6'h0e:        dec.alu_ctr = 4'd6;
          default:      begin dec.ext_op = 2'd2; dec.alu_ctr = 4'd4; end
        endcase
      end
      6'h23, 6'h20, 6'h21, 6'h24, 6'h25: begin
        dec.alu_src    = 2'd1;
        dec.ext_op     = 2'd1;
        dec.alu_ctr    = 4'd1;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = (op == 6'h23) ? 3'd1 : 3'd3;
      end
      6'h2b, 6'h28, 6'h29: begin
        dec.alu_src   = 2'd1;
        dec.ext_op    = 2'd1;
        dec.alu_ctr   = 4'd1;
        dec.mem_write = 1'b1;
      end
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin
        dec.npc_sel = 2'd1;
        dec.ext_op  = 2'd1;
        dec.alu_ctr = 4'd2;
      end
      6'h02: dec.npc_sel = 2'd2;
      6'h03: begin
        dec.npc_sel    = 2'd2;
        dec.reg_dst    = 2'd2;
        dec.mem_to_reg = 3'd2;
        dec.reg_write  = 1'b1;
      end
      6'h10: begin
        if (rs == 5'd4) begin
          dec.write_cp0 = 1'b1;
        end else if (rs == 5'd0) begin
          dec.mem_to_reg = 3'd5;
          dec.reg_write  = 1'b1;
        end else if (rs == 5'h10 && funct == 6'h18) begin
          dec.eret = 1'b1;
        end else begin
          dec_ok = 1'b0;
        end
      end
      default: dec_ok = 1'b0;
    endcase
  end

  logic [0:0]       state_d, state_q;
  logic             valid_d, valid_q, bd_d, bd_q;
  logic [PC_W-1:0]  pc_d, pc_q;
  logic [31:0]      instr_d, instr_q;
  ctrl_t            ctrl_d, ctrl_q;
  logic [EXC_W-1:0] exc_d, exc_q;
  logic             drop, accept, exc_in_v;

  always_comb begin
    drop     = (state_q == ST_SQUASH);
    accept   = in_valid && !drop;
    exc_in_v = in_exc[EXC_W-1];
    state_d  = state_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ctrl_d   = ctrl_q;
    exc_d    = exc_q;
    bd_d     = bd_q;
    if (flush) begin
      // The flush already kills the ERET successor, so a pending squash is moot.
      state_d = ST_RUN;
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = '0;
      ctrl_d  = '0;
      exc_d   = '0;
      bd_d    = 1'b0;
    end else if (!stall) begin
      valid_d = accept;
      pc_d    = in_pc;
      bd_d    = in_bd;
      instr_d = accept ? in_instr : '0;
      ctrl_d  = '0;
      exc_d   = '0;
      if (accept && exc_in_v) begin
        exc_d = in_exc;
        if (dec_ok) begin
          ctrl_d           = dec;
          ctrl_d.reg_write = 1'b0;
          ctrl_d.mem_write = 1'b0;
          ctrl_d.write_cp0 = 1'b0;
        end
      end else if (accept && !dec_ok) begin
        exc_d = {1'b1, RI_TAG};
      end else if (accept) begin
        ctrl_d = dec;
      end
      if (drop && in_valid) begin
        state_d = ST_RUN;
      end else if (accept && dec_ok && dec.eret && !exc_in_v && ERET_SQUASH != 0) begin
        state_d = ST_SQUASH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      ctrl_q  <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_pc         = pc_q;
  assign out_instr      = instr_q;
  assign out_reg_dst    = ctrl_q.reg_dst;
  assign out_alu_src    = ctrl_q.alu_src;
  assign out_mem_to_reg = ctrl_q.mem_to_reg;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_write  = ctrl_q.mem_write;
  assign out_npc_sel    = ctrl_q.npc_sel;
  assign out_ext_op     = ctrl_q.ext_op;
  assign out_alu_ctr    = ctrl_q.alu_ctr;
  assign out_write_cp0  = ctrl_q.write_cp0;
  assign out_eret       = ctrl_q.eret;
  assign out_exc        = exc_q;
  assign out_bd         = bd_q;
  assign squash_pending = (state_q == ST_SQUASH);

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_ctrl.sv
`default_nettype none
// ============================================================================
// tb_decode_stage_ctrl : directed + random bench with a mnemonic-level model
// Rev 1.0
// ============================================================================
module tb_decode_stage_ctrl;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_bd, stall, flush;
  logic [31:0] in_instr, in_pc;
  logic [5:0]  in_exc;
  logic        out_valid, out_reg_write, out_mem_write, out_write_cp0, out_eret, out_bd, squash_pending;
  logic [31:0] out_pc, out_instr;
  logic [1:0]  out_reg_dst, out_alu_src, out_npc_sel, out_ext_op;
  logic [2:0]  out_mem_to_reg;
  logic [3:0]  out_alu_ctr;
  logic [5:0]  out_exc;

  always #5 clk = ~clk;

  decode_stage_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_exc(in_exc), .in_bd(in_bd), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_reg_dst(out_reg_dst), .out_alu_src(out_alu_src), .out_mem_to_reg(out_mem_to_reg),
    .out_reg_write(out_reg_write), .out_mem_write(out_mem_write), .out_npc_sel(out_npc_sel),
    .out_ext_op(out_ext_op), .out_alu_ctr(out_alu_ctr), .out_write_cp0(out_write_cp0),
    .out_eret(out_eret), .out_exc(out_exc), .out_bd(out_bd), .squash_pending(squash_pending)
  );

  typedef struct packed {
    logic [1:0] reg_dst;
    logic [1:0] alu_src;
    logic [2:0] m2r;
    logic       rw;
    logic       mw;
    logic [1:0] npc;
    logic [1:0] ext;
    logic [3:0] alu;
    logic       cp0w;
    logic       eret;
  } ctl_t;

  int n_total = 0;
  int n_pass  = 0;
  bit started = 0;
  int unsigned pc_ctr = 32'h0040_0000;

  // Model state (committed at each edge) and its next value
  logic        m_valid, m_bd, m_sq, n_valid, n_bd, n_sq;
  logic [31:0] m_pc, m_instr, n_pc, n_instr;
  ctl_t        m_ctl, n_ctl;
  logic [5:0]  m_exc, n_exc;

  logic [5:0] op_tab [0:22] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                                6'h06, 6'h07, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
                                6'h0e, 6'h0f, 6'h10, 6'h23, 6'h20, 6'h2b, 6'h29};
  logic [5:0] fn_tab [0:18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2a, 6'h2b, 6'h01};

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  function automatic ctl_t row(input int rd, input int src, input int m2r, input int rw,
                               input int mw, input int npc, input int ext, input int alu,
                               input int cp0, input int er);
    ctl_t c;
    c.reg_dst = 2'(rd);  c.alu_src = 2'(src); c.m2r = 3'(m2r); c.rw = 1'(rw);
    c.mw = 1'(mw);       c.npc = 2'(npc);     c.ext = 2'(ext); c.alu = 4'(alu);
    c.cp0w = 1'(cp0);    c.eret = 1'(er);
    return c;
  endfunction

  // Mnemonic table: returns 0 for reserved instructions.
  function automatic bit ref_decode(input logic [31:0] w, output ctl_t c);
    logic [5:0] op, fn;
    logic [4:0] rs;
    bit ok;
    op = w[31:26]; rs = w[25:21]; fn = w[5:0]; c = '0; ok = 1;
    case (op)
      6'h00: case (fn)
        6'h20, 6'h21: c = row(1,0,0,1,0,0,0,1,0,0);  // add/addu
        6'h22, 6'h23: c = row(1,0,0,1,0,0,0,2,0,0);  // sub/subu
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: c = row(1,2,0,1,0,0,0,4,0,0);
        6'h24: c = row(1,0,0,1,0,0,0,5,0,0);
        6'h25: c = row(1,0,0,1,0,0,0,3,0,0);
        6'h26: c = row(1,0,0,1,0,0,0,6,0,0);
        6'h27: c = row(1,0,0,1,0,0,0,7,0,0);
        6'h2a: c = row(1,0,0,1,0,0,0,8,0,0);
        6'h2b: c = row(1,0,0,1,0,0,0,9,0,0);
        6'h08: c = row(0,0,0,0,0,3,0,0,0,0);         // jr
        6'h09: c = row(1,0,2,1,0,3,0,0,0,0);         // jalr
        default: ok = 0;
      endcase
      6'h0d: c = row(0,1,0,1,0,0,0,3,0,0);
      6'h0c: c = row(0,1,0,1,0,0,0,5,0,0);
      6'h0e: c = row(0,1,0,1,0,0,0,6,0,0);
      6'h08, 6'h09: c = row(0,1,0,1,0,0,1,1,0,0);
      6'h0a: c = row(0,1,0,1,0,0,1,8,0,0);
      6'h0b: c = row(0,1,0,1,0,0,1,9,0,0);
      6'h0f: c = row(0,1,0,1,0,0,2,4,0,0);          // lui
      6'h23: c = row(0,1,1,1,0,0,1,1,0,0);          // lw
      6'h20, 6'h21, 6'h24, 6'h25: c = row(0,1,3,1,0,0,1,1,0,0);
      6'h2b, 6'h28, 6'h29: c = row(0,1,0,0,1,0,1,1,0,0);
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: c = row(0,0,0,0,0,1,1,2,0,0);
      6'h02: c = row(0,0,0,0,0,2,0,0,0,0);
      6'h03: c = row(2,0,2,1,0,2,0,0,0,0);
      6'h10: begin
        if (rs == 5'd4)                     c = row(0,0,0,0,0,0,0,0,1,0);
        else if (rs == 5'd0)                c = row(0,0,5,1,0,0,0,0,0,0);
        else if (rs == 5'h10 && fn == 6'h18) c = row(0,0,0,0,0,0,0,0,0,1);
        else ok = 0;
      end
      default: ok = 0;
    endcase
    return ok;
  endfunction

  task automatic model_next();
    ctl_t c;
    bit ok, drop, acc;
    n_valid = m_valid; n_pc = m_pc; n_instr = m_instr; n_ctl = m_ctl;
    n_exc = m_exc; n_bd = m_bd; n_sq = m_sq;
    if (reset || flush) begin
      n_valid = 0; n_pc = 0; n_instr = 0; n_ctl = '0; n_exc = 0; n_bd = 0; n_sq = 0;
    end else if (!stall) begin
      ok   = ref_decode(in_instr, c);
      drop = m_sq;
      acc  = in_valid && !drop;
      n_valid = acc; n_pc = in_pc; n_bd = in_bd; n_instr = acc ? in_instr : 32'h0;
      n_ctl = '0; n_exc = 0;
      if (acc) begin
        if (in_exc[5]) begin
          n_exc = in_exc;
          if (ok) begin n_ctl = c; n_ctl.rw = 0; n_ctl.mw = 0; n_ctl.cp0w = 0; end
        end else if (!ok) begin
          n_exc = 6'b101010;
        end else begin
          n_ctl = c;
        end
      end
      if (drop && in_valid) n_sq = 0;
      else if (acc && ok && c.eret && !in_exc[5]) n_sq = 1;
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    m_valid = n_valid; m_pc = n_pc; m_instr = n_instr; m_ctl = n_ctl;
    m_exc = n_exc; m_bd = n_bd; m_sq = n_sq;
    started = 1;
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [5:0] e,
                       input logic s, input logic f);
    in_valid = v; in_instr = w; in_exc = e; stall = s; flush = f;
    in_pc = pc_ctr; in_bd = pc_ctr[2]; pc_ctr += 4;
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    k = $urandom_range(0, 99);
    w = $urandom;
    if (k < 8) return 32'h4200_0018;
    if (k < 90) begin
      w[31:26] = op_tab[$urandom_range(0, 22)];
      if (w[31:26] == 6'h00 && $urandom_range(0, 3) != 0) w[5:0] = fn_tab[$urandom_range(0, 18)];
      if (w[31:26] == 6'h10) begin
        case ($urandom_range(0, 3))
          0: w[25:21] = 5'd0;
          1: w[25:21] = 5'd4;
          2: w[25:21] = 5'h10;
          default: ;
        endcase
        if ($urandom_range(0, 1) == 1) w[5:0] = 6'h18;
      end
    end
    return w;
  endfunction

  // Whole-bundle comparison against the model on every cycle
  initial forever begin
    @(negedge clk);
    if (started)
      chk("bundle",
          {out_valid, out_pc, out_instr, out_reg_dst, out_alu_src, out_mem_to_reg,
           out_reg_write, out_mem_write, out_npc_sel, out_ext_op, out_alu_ctr,
           out_write_cp0, out_eret, out_exc, out_bd, squash_pending},
          {m_valid, m_pc, m_instr, m_ctl, m_exc, m_bd, m_sq});
  end

  localparam logic [31:0] ADDU = 32'h0085_1021;
  localparam logic [31:0] ERET = 32'h4200_0018;
  localparam logic [31:0] ORI  = 32'h3401_0005;

  initial begin
    reset = 1; in_valid = 0; in_instr = 0; in_pc = 0; in_exc = 0; in_bd = 0; stall = 0; flush = 0;
    step(); step();
    chk("reset_valid", out_valid, 0);
    chk("reset_sq", squash_pending, 0);
    chk("reset_exc", out_exc, 0);
    reset = 0;

    drive(1, ADDU, 6'h00, 0, 0);
    chk("addu_bundle", {out_valid, out_reg_dst, out_alu_ctr, out_reg_write, out_exc},
        {1'b1, 2'd1, 4'd1, 1'b1, 6'd0});
    drive(1, 32'hFC00_0000, 6'h00, 0, 0);
    chk("ri_exc", out_exc, 6'b101010);
    chk("ri_we", {out_valid, out_reg_write, out_mem_write}, 3'b100);
    drive(1, 32'hAC02_0004, 6'b100100, 0, 0);
    chk("fetch_exc", out_exc, 6'b100100);
    chk("fetch_exc_mw", out_mem_write, 0);
    drive(1, 32'h0000_0000, 6'h00, 0, 0);
    chk("nop", {out_valid, out_reg_write, out_exc}, {1'b1, 1'b1, 6'd0});

    drive(1, ADDU, 6'h00, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 6'h00, 1, 0);
      chk("stall_hold", {out_instr, out_alu_ctr, out_valid}, {ADDU, 4'd1, 1'b1});
    end
    drive(1, ORI, 6'h00, 1, 1);
    chk("stall_flush", {out_valid, out_reg_write, out_pc}, 34'd0);

    drive(1, ERET, 6'h00, 0, 0);
    chk("eret", {out_eret, squash_pending}, 2'b11);
    drive(0, ORI, 6'h00, 0, 0);
    chk("sq_idle", {out_valid, squash_pending}, 2'b01);
    drive(1, ORI, 6'h00, 0, 0);
    chk("sq_drop", {out_valid, squash_pending, out_reg_write}, 3'b000);
    drive(1, ORI, 6'h00, 0, 0);
    chk("after_sq", {out_valid, out_alu_ctr}, {1'b1, 4'd3});

    drive(1, ERET, 6'b100001, 0, 0);
    chk("eret_exc_nosq", {squash_pending, out_exc}, {1'b0, 6'b100001});
    drive(1, ERET, 6'h00, 0, 0);
    drive(1, ORI, 6'h00, 0, 1);
    chk("sq_flush", {out_valid, squash_pending}, 2'b00);
    drive(1, ORI, 6'h00, 0, 0);
    chk("flush_run", out_valid, 1);

    drive(1, ERET, 6'h00, 0, 0);
    reset = 1;
    drive(1, ORI, 6'h00, 0, 0);
    chk("mid_reset", {out_valid, out_eret, squash_pending, out_pc}, 35'd0);
    reset = 0;
    drive(1, ORI, 6'h00, 0, 0);
    chk("post_reset_ori", out_valid, 1);

    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 9) < 8);
      stall    = ($urandom_range(0, 99) < 15);
      flush    = ($urandom_range(0, 99) < 5);
      in_exc   = ($urandom_range(0, 9) == 0) ? {1'b1, 5'($urandom)} : {1'b0, 5'($urandom)};
      in_instr = rand_instr();
      in_pc    = $urandom;
      in_bd    = 1'($urandom_range(0, 1));
      step();
    end
    reset = 0; stall = 0; flush = 0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
